// File: rtl/onehot_dec_pkg.sv
// rtl/onehot_dec_pkg.sv - shared state enum, counter width and index decode helper
package onehot_dec_pkg;

  localparam int CNT_W = 8;
  localparam int MAX_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Out-of-range indices decode to all-zero so a caller can never see multi-hot.
  function automatic logic [MAX_W-1:0] idx_to_onehot(input int idx, input int width);
    logic [MAX_W-1:0] r;
    r = '0;
    if (idx >= 0 && idx < width) r = MAX_W'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter timing the HOLD and GAP phases
module dwell_timer
  import onehot_dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so the idle state needs no explicit enable.
  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - decodes an accepted index into a timed one-hot strobe
module onehot_pulse_decoder
  import onehot_dec_pkg::*;
#(
  parameter int IDX_W = 3,
  parameter int OUT_W = 8,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_none,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_onehot,
  output logic             err,
  output logic [7:0]       pulse_cnt
);

  if (IDX_W < 1 || IDX_W > 8) begin : g_bad_idx_w
    $error("onehot_pulse_decoder: IDX_W must be 1..8");
  end
  if (OUT_W < 1 || OUT_W > (2 ** IDX_W)) begin : g_bad_out_w
    $error("onehot_pulse_decoder: OUT_W must be 1..2**IDX_W");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("onehot_pulse_decoder: HOLD must be 1..255");
  end
  if (GAP < 0 || GAP > 255) begin : g_bad_gap
    $error("onehot_pulse_decoder: GAP must be 0..255");
  end

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_onehot_q, out_onehot_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;
  logic             accept;
  logic             idx_oor;

  assign accept  = in_valid && (state_q == ST_IDLE);
  assign idx_oor = int'(in_idx) >= OUT_W;

  always_comb begin
    state_d      = state_q;
    out_onehot_d = out_onehot_q;
    out_valid_d  = out_valid_q;
    err_d        = 1'b0;
    pulse_cnt_d  = pulse_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = HOLD_LD;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // in_none takes precedence over a range error on the same request.
          if (in_none) begin
            state_d      = ST_HOLD;
            out_onehot_d = '0;
            out_valid_d  = 1'b1;
            tmr_load     = 1'b1;
          end else if (idx_oor) begin
            err_d = 1'b1;
          end else begin
            state_d      = ST_HOLD;
            out_onehot_d = OUT_W'(idx_to_onehot(int'(in_idx), OUT_W));
            out_valid_d  = 1'b1;
            tmr_load     = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          pulse_cnt_d  = pulse_cnt_q + CNT_W'(1);
          out_onehot_d = '0;
          out_valid_d  = 1'b0;
          if (GAP > 0) begin
            state_d      = ST_GAP;
            tmr_load     = 1'b1;
            tmr_load_val = GAP_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        out_onehot_d = '0;
        out_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_onehot_q <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      pulse_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_onehot_q <= out_onehot_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      pulse_cnt_q  <= pulse_cnt_d;
    end
  end

  dwell_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign err        = err_q;
  assign pulse_cnt  = pulse_cnt_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - directed bench for onehot_pulse_decoder
module tb_onehot_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_idx = '0;
  logic       in_none = 1'b0;
  logic       out_valid;
  logic [7:0] out_onehot;
  logic       err;
  logic [7:0] pulse_cnt;

  logic       v6_valid = 1'b0;
  logic       r6_ready;
  logic [2:0] v6_idx = '0;
  logic       v6_none = 1'b0;
  logic       o6_valid;
  logic [5:0] o6_onehot;
  logic       e6_err;
  logic [7:0] p6_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.IDX_W(3), .OUT_W(8), .HOLD(4), .GAP(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_none    (in_none),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .err        (err),
    .pulse_cnt  (pulse_cnt)
  );

  onehot_pulse_decoder #(.IDX_W(3), .OUT_W(6), .HOLD(4), .GAP(1)) u_dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v6_valid),
    .in_ready   (r6_ready),
    .in_idx     (v6_idx),
    .in_none    (v6_none),
    .out_valid  (o6_valid),
    .out_onehot (o6_onehot),
    .err        (e6_err),
    .pulse_cnt  (p6_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_none = 1'b0; in_idx = '0;
    v6_valid = 1'b0; v6_none = 1'b0; v6_idx = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference 8-to-3 priority encoder: highest set bit wins, -1 when empty.
  function automatic int penc(input logic [7:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    // 1. reset state
    rst_n = 1'b0;
    #2;
    chk("rst_onehot", 32'(out_onehot), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cnt", 32'(pulse_cnt), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    do_reset();

    // 2. single pulse, idx=3
    in_idx = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("single_onehot", 32'(out_onehot), 32'h08);
      chk("single_valid", 32'(out_valid), 32'h1);
      chk("single_ready", 32'(in_ready), 32'h0);
      tick();
    end
    chk("single_gap_onehot", 32'(out_onehot), 32'h0);
    chk("single_gap_valid", 32'(out_valid), 32'h0);
    chk("single_gap_ready", 32'(in_ready), 32'h0);
    tick();
    chk("single_ready_back", 32'(in_ready), 32'h1);
    chk("single_cnt", 32'(pulse_cnt), 32'h1);

    // 3. back-to-back with valid held high
    do_reset();
    in_idx = 3'd0; in_valid = 1'b1;
    tick();
    in_idx = 3'd7;
    for (int c = 1; c <= 4; c++) begin
      chk("b2b_first", 32'(out_onehot), 32'h01);
      tick();
    end
    chk("b2b_gap", 32'(out_onehot), 32'h0);
    chk("b2b_gap_ready", 32'(in_ready), 32'h0);
    tick();
    chk("b2b_ready_c6", 32'(in_ready), 32'h1);
    chk("b2b_cnt_mid", 32'(pulse_cnt), 32'h1);
    tick();
    in_valid = 1'b0;
    for (int c = 7; c <= 10; c++) begin
      chk("b2b_second", 32'(out_onehot), 32'h80);
      chk("b2b_second_valid", 32'(out_valid), 32'h1);
      tick();
    end
    chk("b2b_end", 32'(out_onehot), 32'h0);
    chk("b2b_cnt", 32'(pulse_cnt), 32'h2);

    // 4. empty request
    do_reset();
    in_idx = 3'd5; in_none = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_none = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("none_valid", 32'(out_valid), 32'h1);
      chk("none_onehot", 32'(out_onehot), 32'h0);
      chk("none_err", 32'(err), 32'h0);
      tick();
    end
    chk("none_valid_end", 32'(out_valid), 32'h0);
    chk("none_cnt", 32'(pulse_cnt), 32'h1);

    // 5a. range error on OUT_W=6 instance
    do_reset();
    v6_idx = 3'd6; v6_valid = 1'b1;
    tick();
    v6_valid = 1'b0;
    chk("oor_err", 32'(e6_err), 32'h1);
    chk("oor_valid", 32'(o6_valid), 32'h0);
    chk("oor_ready", 32'(r6_ready), 32'h1);
    tick();
    chk("oor_err_clear", 32'(e6_err), 32'h0);
    chk("oor_cnt", 32'(p6_cnt), 32'h0);
    v6_idx = 3'd5; v6_valid = 1'b1;
    tick();
    v6_valid = 1'b0;
    chk("w6_top_idx", 32'(o6_onehot), 32'h20);
    repeat (5) tick();
    v6_idx = 3'd7; v6_none = 1'b1; v6_valid = 1'b1;
    tick();
    v6_valid = 1'b0; v6_none = 1'b0;
    chk("none_oor_err", 32'(e6_err), 32'h0);
    chk("none_oor_valid", 32'(o6_valid), 32'h1);
    chk("none_oor_onehot", 32'(o6_onehot), 32'h0);

    // 5b. asynchronous reset mid-HOLD
    do_reset();
    in_idx = 3'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midrst_pre", 32'(out_onehot), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("midrst_onehot", 32'(out_onehot), 32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // 6a. round trip through the priority encoder model
    for (int i = 0; i < 8; i++) begin
      in_idx = 3'(i); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rt_encode", 32'(penc(out_onehot)), 32'(i));
      for (int c = 0; c < 5; c++) begin
        chk("rt_not_multihot", 32'($countones(out_onehot) <= 1), 32'h1);
        tick();
      end
    end
    chk("rt_cnt", 32'(pulse_cnt), 32'h8);

    // 6b. 256 pulses wrap the counter
    do_reset();
    in_idx = 3'd2; in_valid = 1'b1;
    repeat (1529) tick();
    chk("wrap_255", 32'(pulse_cnt), 32'hff);
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("wrap_0", 32'(pulse_cnt), 32'h0);
    chk("wrap_valid", 32'(out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_pulse_decoder.md
Name: onehot_pulse_decoder

Overview:
Inverse of the team's 8-to-3 priority encoder: accepts an encoded index over a valid/ready handshake and drives the matching one-hot strobe, held for a programmable number of cycles, followed by a programmable idle gap. It sits on the select side of encoder-driven datapaths, such as arbitration grants and channel enables. Its one-hot output feeds back into the priority encoder for round-trip checking.

Parameters:
IDX_W, 3, width of the encoded index.
OUT_W, 8, width of the one-hot output; legal range 1..2**IDX_W.
HOLD, 4, cycles each one-hot pulse is held; legal range 1..255.
GAP, 1, forced all-zero cycles after each pulse; legal range 0..255.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
in_idx  input  IDX_W  encoded index to decode
in_none  input  1  request carries "no bit set" (encoder empty case)
out_valid  output  1  a pulse window is active
out_onehot  output  OUT_W  decoded strobe, registered
err  output  1  one-cycle flag: in_idx >= OUT_W was accepted
pulse_cnt  output  8  count of completed pulse windows, wraps

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately, including mid-pulse: state=IDLE, out_onehot=0, out_valid=0, err=0, pulse_cnt=0, in_ready=1.
- FSM states: IDLE, HOLD, GAP.
- Accept: a request is accepted when in_valid && in_ready; in_ready=1 only in IDLE.
- Source rules: in_idx and in_none must stay stable while in_valid is high and the request is not yet accepted. Deasserting valid before acceptance is allowed; the request is then dropped and never decoded.
- IDLE, normal accept (in_idx < OUT_W, in_none=0): next cycle enters HOLD; out_onehot = 1 << in_idx; out_valid=1; hold counter loaded with HOLD-1. Latency from accept edge to output: 1 cycle.
- IDLE, accept with in_none=1: same as a normal accept, but out_onehot=0 while out_valid=1 for HOLD cycles. This case counts as a pulse window.
- IDLE, accept with in_idx >= OUT_W and in_none=0:
  - the request is consumed;
  - err=1 for exactly the next cycle;
  - the FSM stays in IDLE with in_ready=1 on that cycle;
  - no pulse is issued and pulse_cnt is unchanged.
- If in_none=1 and in_idx is out of range in the same request, in_none wins and no err is raised.
- HOLD: outputs are held constant and the counter decrements each cycle. On the cycle the counter is 0:
  - pulse_cnt increments, wrapping 255 -> 0;
  - the FSM goes to GAP with counter GAP-1 if GAP>0, otherwise to IDLE.
  - out_onehot and out_valid clear on the transition edge.
- GAP: out_onehot=0, out_valid=0, in_ready=0. The counter decrements; at 0 the FSM goes to IDLE.
- Throughput: with a continuously valid source, accepts are spaced HOLD+GAP+1 cycles apart.
- out_onehot is always zero or exactly one-hot; it is never multi-hot, including across transitions.
- Parameters outside the legal ranges cause an elaboration-time error.

Decomposition:
- Package onehot_dec_pkg holds:
  - the state enum (IDLE, HOLD, GAP);
  - localparam CNT_W = 8;
  - a function idx_to_onehot(idx, width), shared with the testbenches.
- One sub-module is natural: dwell_timer. It is a loadable down-counter with load, value and zero flag, and is reused for both the HOLD and GAP phases.

Test Plan (defaults HOLD=4, GAP=1, OUT_W=8):
1. Reset: rst_n=0 then 1, no input -> out_onehot=8'b0, out_valid=0, err=0, pulse_cnt=0, in_ready=1.
2. Single pulse: in_idx=3 valid for 1 cycle at cycle 0 ->
   - out_onehot=8'b00001000 and out_valid=1 on cycles 1-4;
   - all zero on cycle 5;
   - in_ready=1 again at cycle 6;
   - pulse_cnt=1.
3. Back-to-back: idx=0, then idx=7 with in_valid held high ->
   - 8'b00000001 for 4 cycles, 1 zero cycle;
   - idx=7 accepted at cycle 6, then 8'b10000000 for 4 cycles;
   - pulse_cnt=2.
4. Empty case: in_none=1 with in_idx=5 -> out_valid=1 and out_onehot=0 for 4 cycles; err=0; pulse_cnt=1.
5. Range error and mid-pulse reset:
   - with OUT_W=6, in_idx=6 -> err=1 for one cycle, no out_valid, in_ready stays 1;
   - separately, rst_n low on cycle 2 of a HOLD -> outputs are zero in the same cycle.
6. Round-trip and wrap:
   - drive all indices 0..7 in sequence, feed out_onehot into the priority encoder, and check that each encoded result equals the index driven;
   - issue 256 pulses and check that pulse_cnt wraps to 0.
